fetch_pc_unit: RTL

- Program-counter and fetch-control stage directly upstream of the instruction memory in the single-cycle RV32I core.
- Holds the PC, drives the byte address into instruction memory, and receives back the assembled 32-bit instruction word.
- Computes the next PC from sequential, redirect (branch/jal/jalr) and stall inputs.
- A small state machine halts the core on ECALL/EBREAK and traps on misaligned or out-of-range fetch targets; a retired-instruction counter is kept.

---
 rtl/core_pkg.sv | 21 ++
 rtl/fetch_pc_unit_if.sv | 27 ++
 rtl/next_pc_sel.sv | 26 ++
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the RV32I fetch stage
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] ECALL_INSN  = 32'h0000_0073;
    localparam logic [XLEN-1:0] EBREAK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        TRAP = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        MISALIGNED   = 2'd1,
        OUT_OF_RANGE = 2'd2
    } trap_cause_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - control, instruction-memory and status signals of the fetch stage
interface fetch_pc_unit_if #(
    parameter int CNT_W = 32
);
    logic                      stall;
    logic                      redirect_valid;
    logic [core_pkg::XLEN-1:0] redirect_target;
    logic                      resume;
    logic [core_pkg::XLEN-1:0] instruction;
    logic [core_pkg::XLEN-1:0] pc;
    logic [core_pkg::XLEN-1:0] pc_plus4;
    logic                      fetch_valid;
    logic                      halted;
    logic                      trap;
    logic [1:0]                trap_cause;
    logic [CNT_W-1:0]          retired;

    modport master (
        input  stall, redirect_valid, redirect_target, resume, instruction,
        output pc, pc_plus4, fetch_valid, halted, trap, trap_cause, retired
    );

    modport slave (
        output stall, redirect_valid, redirect_target, resume, instruction,
        input  pc, pc_plus4, fetch_valid, halted, trap, trap_cause, retired
    );
endinterface

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - next-PC candidate selection with alignment and range checks
module next_pc_sel
    import core_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            use_redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned,
    output logic            out_of_range
);

    logic [XLEN:0] next_wide;

    // One extra bit so pc+4 wrapping past the top of the address space still reads as out of range.
    always_comb begin
        next_wide    = use_redirect ? {1'b0, redirect_target}
                                    : {1'b0, pc} + (XLEN+1)'(4);
        next_pc      = next_wide[XLEN-1:0];
        misaligned   = use_redirect && (redirect_target[1:0] != 2'b00);
        out_of_range = (next_wide + (XLEN+1)'(3)) >= (XLEN+1)'(IMEM_BYTES);
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC register, RUN/HALT/TRAP control and retired-instruction counter
module fetch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 32,
    parameter int          CNT_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus
);

    fetch_state_t     state_q;
    trap_cause_t      cause_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q;
    logic             fetch_valid_q;
    logic             halted_q;
    logic             trap_q;

    logic [XLEN-1:0]  next_pc;
    logic             misaligned;
    logic             out_of_range;
    logic             halt_insn;
    logic [CNT_W-1:0] retired_inc;

    assign halt_insn   = (bus.instruction == ECALL_INSN) || (bus.instruction == EBREAK_INSN);
    assign retired_inc = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);

    // Redirects only matter in RUN; HALT always resumes at the sequential address.
    next_pc_sel #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_next_pc_sel (
        .pc              (pc_q),
        .use_redirect    ((state_q == RUN) && bus.redirect_valid),
        .redirect_target (bus.redirect_target),
        .next_pc         (next_pc),
        .misaligned      (misaligned),
        .out_of_range    (out_of_range)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            cause_q       <= NONE;
            pc_q          <= RESET_PC;
            retired_q     <= '0;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!bus.stall) begin
                        if (halt_insn) begin
                            retired_q     <= retired_inc;
                            state_q       <= HALT;
                            fetch_valid_q <= 1'b0;
                            halted_q      <= 1'b1;
                        end else if (misaligned) begin
                            state_q       <= TRAP;
                            cause_q       <= MISALIGNED;
                            fetch_valid_q <= 1'b0;
                            trap_q        <= 1'b1;
                        end else if (out_of_range) begin
                            // A sequential fall-off still retires the instruction at pc; a bad redirect does not.
                            if (!bus.redirect_valid) begin
                                retired_q <= retired_inc;
                            end
                            state_q       <= TRAP;
                            cause_q       <= OUT_OF_RANGE;
                            fetch_valid_q <= 1'b0;
                            trap_q        <= 1'b1;
                        end else begin
                            pc_q      <= next_pc;
                            retired_q <= retired_inc;
                        end
                    end
                end
                HALT: begin
                    if (bus.resume) begin
                        halted_q <= 1'b0;
                        if (out_of_range) begin
                            state_q <= TRAP;
                            cause_q <= OUT_OF_RANGE;
                            trap_q  <= 1'b1;
                        end else begin
                            pc_q          <= next_pc;
                            state_q       <= RUN;
                            fetch_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // TRAP is sticky until reset.
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + 32'd4;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = cause_q;
    assign bus.retired     = retired_q;

endmodule
